fifo_ctrl_flags: RTL and testbench

Parametrised single-clock synchronous FIFO. Successor to the basic fifo block.
- Supports arbitrary (non-power-of-2) depth and exact occupancy count.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a read-valid strobe.
- Sits between producer/consumer datapaths in the same clock domain as a rate-smoothing buffer.

---
 rtl/fifo_ctrl_flags.sv | 120 ++++++++++++
 tb/tb_fifo_ctrl_flags.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_flags.sv
// Single-clock FIFO with exact occupancy count, almost-full/almost-empty flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output (zero read latency); default is registered read.
module fifo_ctrl_flags #(
  parameter int DATA_W = 8,
  parameter int L      = 10,
  parameter int AF_TH  = L - 2,
  parameter int AE_TH  = 2,
  parameter int ADD_W  = $clog2(L),
  parameter int CNT_W  = $clog2(L + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [L];

  logic [ADD_W-1:0] wr_ptr_reg;
  logic [ADD_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             empty_int;
  logic             full_int;
  logic             rd_acc;
  logic             wr_acc;

  // Pointers wrap explicitly so any depth works, not just powers of two.
  function automatic logic [ADD_W-1:0] ptr_inc(input logic [ADD_W-1:0] p);
    return (p == ADD_W'(L - 1)) ? '0 : p + ADD_W'(1);
  endfunction

  assign empty_int = (count_reg == '0);
  assign full_int  = (count_reg == CNT_W'(L));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en & ~empty_int;
  assign wr_acc = wr_en & (~full_int | rd_acc);

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_acc) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
      if (wr_en && !wr_acc) overflow_reg  <= 1'b1;
      if (rd_en && !rd_acc) underflow_reg <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_acc && !clr) mem[wr_ptr_reg] <= din;
  end

`ifdef FIFO_FWFT_EN
  assign dout     = empty_int ? '0 : mem[rd_ptr_reg];
  assign rd_valid = ~empty_int;
`else
  logic [DATA_W-1:0] dout_reg;
  logic              rd_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_reg     <= '0;
      rd_valid_reg <= 1'b0;
    end else if (clr) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) dout_reg <= mem[rd_ptr_reg];
    end
  end

  assign dout     = dout_reg;
  assign rd_valid = rd_valid_reg;
`endif

  assign count        = count_reg;
  assign empty        = empty_int;
  assign full         = full_int;
  assign almost_full  = (count_reg >= CNT_W'(AF_TH));
  assign almost_empty = (count_reg <= CNT_W'(AE_TH));
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl_flags.sv
// Randomised self-checking bench for fifo_ctrl_flags against a queue-based reference model.
// Builds for either output mode; FIFO_FWFT_EN selects the fall-through expectations.
module tb_fifo_ctrl_flags;

  localparam int DATA_W = 8;
  localparam int L      = 10;
  localparam int AF_TH  = 8;
  localparam int AE_TH  = 2;
  localparam int CNT_W  = $clog2(L + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  fifo_ctrl_flags #(
    .DATA_W(DATA_W),
    .L(L),
    .AF_TH(AF_TH),
    .AE_TH(AE_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .wr_en(wr_en),
    .din(din),
    .rd_en(rd_en),
    .dout(dout),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int step_cnt = 0;

  // Reference model: contents as a plain queue plus the externally visible sticky state.
  logic [DATA_W-1:0] m_q [$];
  logic              m_ovf;
  logic              m_unf;
  logic              m_rv;
  logic [DATA_W-1:0] m_dout;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rv   = 1'b0;
    m_dout = '0;
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    check_val("count", 32'(count), 32'(n));
    check_val("full", 32'(full), 32'(n == L));
    check_val("empty", 32'(empty), 32'(n == 0));
    check_val("almost_full", 32'(almost_full), 32'(n >= AF_TH));
    check_val("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    check_val("rd_valid", 32'(rd_valid), 32'(n != 0));
    check_val("dout", 32'(dout), (n != 0) ? 32'(m_q[0]) : 32'd0);
`else
    check_val("rd_valid", 32'(rd_valid), 32'(m_rv));
    check_val("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  // One clock transaction: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    int  n;
    logic rd_ok;
    logic wr_ok;
    wr_en = w;
    din   = d;
    rd_en = r;
    clr   = c;
    @(posedge clk);
    n = m_q.size();
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      rd_ok = r && (n != 0);
      wr_ok = w && ((n != L) || rd_ok);
      m_rv  = rd_ok;
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
    end
    #1;
    check_all();
    step_cnt++;
    $display("step %0d wr=%b din=%02h rd=%b clr=%b -> count=%0d dout=%02h rd_valid=%b ovf=%b unf=%b",
             step_cnt, w, d, r, c, count, dout, rd_valid, overflow, underflow);
  endtask

  task automatic async_reset_check();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    rst   = 1'b0;
    #2;
    model_reset();
    check_all();
    $display("async reset asserted at t=%0t -> count=%0d empty=%b dout=%02h", $time, count, empty, dout);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int pw;
    int pr;
    model_reset();
    #12;
    check_all();
    $display("reset state: count=%0d empty=%b almost_full=%b almost_empty=%b", count, empty, almost_full, almost_empty);
    rst = 1'b1;

    // Write three, read three.
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill past full, then drain in order.
    for (int i = 0; i <= 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)  step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Steady-state streaming across two pointer wraps.
    for (int i = 0; i < 7; i++)  step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)  step(1'b0, 8'h00, 1'b1, 1'b0);

    // Read+write on empty: read rejected, write kept; then flush.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Read+write on full, drain, then async reset in the middle of a burst.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)  step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b1, 1'b0);
    step(1'b1, 8'h81, 1'b1, 1'b0);
    async_reset_check();

    // Randomised phases with shifting read/write bias.
    for (int i = 0; i < 1200; i++) begin
      case ((i / 150) % 4)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        2:       begin pw = 60; pr = 60; end
        default: begin pw = 95; pr = 95; end
      endcase
      step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr, $urandom_range(99) < 2);
      if (i == 700) async_reset_check();
    end

    step(1'b0, 8'h00, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
